// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- multiply/divide unit with HI/LO result registers.
//
// Accepts one multiply or divide at a time and commits the 2*WIDTH-bit
// result into HI/LO after a fixed latency. MTHI/MTLO write HI/LO directly
// while the unit is idle.
//
// Ports
//   clk      in   1      single clock, rising edge
//   reset    in   1      synchronous, active-high reset
//   start    in   1      request strobe; op/operands sampled when high
//   op       in   3      000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                        101 MTHI, 110 MTLO, 111 reserved
//   rs_data  in   WIDTH  operand A (multiplicand / dividend / MTHI/MTLO src)
//   rt_data  in   WIDTH  operand B (multiplier / divisor)
//   busy     out  1      high while a multiply/divide is in flight
//   done     out  1      one-cycle pulse in the cycle after HI/LO commit
//   hi       out  WIDTH  registered HI
//   lo       out  WIDTH  registered LO
// ---------------------------------------------------------------------------
module mdu #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Result is computed from the operands at accept and held here until
    // the latency expires, so later input changes cannot disturb it.
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;
    logic               r_res_wr;

    op_e                w_op;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic               w_div_ovf;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               w_res_wr;

    assign w_op = op_e'(op);

    // Operands are widened to the full product width first so the multiply
    // is evaluated at 2*WIDTH bits with the correct extension.
    assign w_prod_s = $signed({{WIDTH{rs_data[WIDTH-1]}}, rs_data}) *
                      $signed({{WIDTH{rt_data[WIDTH-1]}}, rt_data});
    assign w_prod_u = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};

    // The single signed quotient that does not fit in WIDTH bits.
    assign w_div_ovf = (rs_data == MOST_NEG) && (rt_data == ALL_ONES);

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        w_res_wr = 1'b0;
        case (w_op)
            OP_MULT: begin
                {w_res_hi, w_res_lo} = w_prod_s;
                w_res_wr             = 1'b1;
            end
            OP_MULTU: begin
                {w_res_hi, w_res_lo} = w_prod_u;
                w_res_wr             = 1'b1;
            end
            OP_DIV: begin
                // Divide by zero still runs full latency but leaves HI/LO alone.
                if (rt_data != '0) begin
                    w_res_wr = 1'b1;
                    if (w_div_ovf) begin
                        w_res_lo = MOST_NEG;
                        w_res_hi = '0;
                    end else begin
                        // SV signed / and % truncate toward zero and give the
                        // remainder the dividend's sign.
                        w_res_lo = $signed(rs_data) / $signed(rt_data);
                        w_res_hi = $signed(rs_data) % $signed(rt_data);
                    end
                end
            end
            OP_DIVU: begin
                if (rt_data != '0) begin
                    w_res_wr = 1'b1;
                    w_res_lo = rs_data / rt_data;
                    w_res_hi = rs_data % rt_data;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: the result holding registers are reset along with HI/LO; they
    // are few and resetting them keeps every internal node X-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_res_wr <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (w_op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_state  <= S_RUN;
                                r_busy   <= 1'b1;
                                r_cnt    <= ((w_op == OP_MULT) || (w_op == OP_MULTU))
                                            ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                                r_res_hi <= w_res_hi;
                                r_res_lo <= w_res_lo;
                                r_res_wr <= w_res_wr;
                            end
                            OP_MTHI: r_hi <= rs_data;
                            OP_MTLO: r_lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    // Last in-flight cycle: commit and return to idle.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_res_wr) begin
                            r_hi <= r_res_hi;
                            r_lo <= r_res_lo;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu (WIDTH=32, MULT_LAT=5, DIV_LAT=10).
// A timeline model (commit edge number + 64-bit arithmetic results) predicts
// busy/done/hi/lo; a compare process checks them every cycle. Directed
// scenarios pin the model with literal values, then random traffic follows.
// ---------------------------------------------------------------------------
module tb_mdu;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    mdu #(.WIDTH(32), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          edge_n    = 0;
    int          commit_at = 0;
    bit          m_busy    = 1'b0;
    bit          m_done    = 1'b0;
    logic [31:0] m_hi      = '0;
    logic [31:0] m_lo      = '0;
    bit          pend_wr;
    logic [31:0] pend_hi, pend_lo;

    always @(posedge clk) begin : model
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        edge_n++;
        m_done = 1'b0;
        if (reset) begin
            m_busy = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_busy) begin
            if (edge_n == commit_at) begin
                if (pend_wr) begin
                    m_hi = pend_hi;
                    m_lo = pend_lo;
                end
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (start) begin
            sa = $signed(rs_data);
            sb = $signed(rt_data);
            ua = rs_data;
            ub = rt_data;
            case (op)
                OP_MULT: begin
                    sp = sa * sb;
                    pend_hi = sp[63:32]; pend_lo = sp[31:0]; pend_wr = 1'b1;
                    m_busy = 1'b1; commit_at = edge_n + MULT_LAT;
                end
                OP_MULTU: begin
                    up = ua * ub;
                    pend_hi = up[63:32]; pend_lo = up[31:0]; pend_wr = 1'b1;
                    m_busy = 1'b1; commit_at = edge_n + MULT_LAT;
                end
                OP_DIV: begin
                    // 64-bit arithmetic covers MIN / -1 without overflow.
                    pend_wr = (rt_data != 0);
                    if (pend_wr) begin
                        sq = sa / sb; sr = sa % sb;
                        pend_lo = sq[31:0]; pend_hi = sr[31:0];
                    end
                    m_busy = 1'b1; commit_at = edge_n + DIV_LAT;
                end
                OP_DIVU: begin
                    pend_wr = (rt_data != 0);
                    if (pend_wr) begin
                        up = ua / ub; pend_lo = up[31:0];
                        up = ua % ub; pend_hi = up[31:0];
                    end
                    m_busy = 1'b1; commit_at = edge_n + DIV_LAT;
                end
                OP_MTHI: m_hi = rs_data;
                OP_MTLO: m_lo = rs_data;
                default: ;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", 64'(busy), 64'(m_busy));
            check("cyc_done", 64'(done), 64'(m_done));
            check("cyc_hi",   64'(hi),   64'(m_hi));
            check("cyc_lo",   64'(lo),   64'(m_lo));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start   = s;
        op      = o;
        rs_data = a;
        rt_data = b;
    endtask

    // Present a request for one edge, then scramble the inputs so the DUT
    // must rely on what it latched.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(1'b1, o, a, b);
        @(negedge clk);
        drive(1'b0, OP_NONE, $urandom, $urandom);
    endtask

    task automatic wait_done(output int nbusy, output bit seen);
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int nb;
        bit seen;
        issue(o, a, b);
        wait_done(nb, seen);
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        check({name, "_busy_cycles"}, 64'(nb), 64'(lat));
        check({name, "_hi"}, 64'(hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- test sequence ----------------
    initial begin : stim
        int nb;
        bit seen;
        int ndone;

        reset = 1'b1;
        drive(1'b1, OP_MULT, 32'h1234, 32'h5678);   // start must lose to reset
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        reset = 1'b0;
        drive(1'b0, OP_NONE, '0, '0);

        run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu",     OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, MULT_LAT, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",      OP_DIVU,  32'h0000_0007, 32'h0000_0002, DIV_LAT,  32'h0000_0001, 32'h0000_0003);
        run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,  32'h0000_0000, 32'h8000_0000);

        // MTHI, then a divide by zero leaves HI/LO untouched.
        @(negedge clk);
        drive(1'b1, OP_MTHI, 32'h1234_5678, '0);
        @(negedge clk);
        drive(1'b0, OP_NONE, '0, '0);
        check("mthi_hi",   64'(hi),   64'h1234_5678);
        check("mthi_busy", 64'(busy), 64'd0);
        run_op("divu_zero", OP_DIVU, 32'h0000_0005, 32'h0000_0000, DIV_LAT, 32'h1234_5678, 32'h8000_0000);

        // Requests while busy are ignored; the in-flight DIVU still commits.
        issue(OP_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, OP_MULT, 32'd3, 32'd4);
        @(negedge clk);
        drive(1'b1, OP_MTLO, 32'h0000_AAAA, '0);
        @(negedge clk);
        drive(1'b0, OP_NONE, '0, '0);
        wait_done(nb, seen);
        check("busy_ign_done_seen", 64'(seen), 64'd1);
        check("busy_ign_rest",      64'(nb),   64'd6);
        check("busy_ign_hi",        64'(hi),   64'd2);
        check("busy_ign_lo",        64'(lo),   64'd14);
        @(negedge clk);
        drive(1'b1, OP_MTLO, 32'h0000_AAAA, '0);
        @(negedge clk);
        drive(1'b0, OP_NONE, '0, '0);
        check("mtlo_lo", 64'(lo), 64'h0000_AAAA);
        check("mtlo_hi", 64'(hi), 64'd2);

        // NONE and reserved requests change nothing.
        @(negedge clk);
        drive(1'b1, OP_NONE, 32'hDEAD_BEEF, 32'd1);
        @(negedge clk);
        drive(1'b1, 3'b111, 32'hDEAD_BEEF, 32'd1);
        @(negedge clk);
        drive(1'b0, OP_NONE, '0, '0);
        check("nop_busy", 64'(busy), 64'd0);
        check("nop_lo",   64'(lo),   64'h0000_AAAA);

        // Reset in the middle of a multiply discards it.
        issue(OP_MULT, 32'd3, 32'd5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi",   64'(hi),   64'd0);
        check("midrst_lo",   64'(lo),   64'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", 64'(ndone), 64'd0);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 149) == 0);
            drive($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), pick(), pick());
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, OP_NONE, '0, '0);
        for (int i = 0; i < DIV_LAT + 2; i++) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, 32, operand and HI/LO width in bits (>=8).
REQ-002 Parameter MULT_LAT, 5, multiply latency in cycles (>=1).
REQ-003 Parameter DIV_LAT, 10, divide latency in cycles (>=1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request; op/operands sampled when start=1.
REQ-007 op  input  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 111 reserved.
REQ-008 rs_data  input  WIDTH  operand A (dividend / multiplicand / MTHI/MTLO source).
REQ-009 rt_data  input  WIDTH  operand B (divisor / multiplier).
REQ-010 busy  output  1  high while a multiply/divide is in flight.
REQ-011 done  output  1  one-cycle pulse in the cycle after results commit.
REQ-012 hi  output  WIDTH  registered HI.
REQ-013 lo  output  WIDTH  registered LO.

Function
REQ-014 Two states: IDLE (busy=0) and RUN (busy=1); busy is a registered decode of state.
REQ-015 Accept: edge where state=IDLE, start=1, op in {MULT,MULTU,DIV,DIVU}; latch operands and op, load counter with MULT_LAT or DIV_LAT, go RUN.
REQ-016 Accepted at edge t -> busy=1 for cycles t+1..t+LAT; HI/LO update and busy falls at edge t+LAT; done=1 for exactly the cycle after edge t+LAT.
REQ-017 In RUN, counter decrements each edge; transition to IDLE when it reaches 1 -> 0; no early completion.
REQ-018 start while busy=1 is ignored (no queueing); latched operands unaffected by later input changes.
REQ-019 MTHI/MTLO with start=1 and busy=0: hi (resp. lo) <= rs_data at that edge; busy and done stay 0; ignored while busy=1.
REQ-020 start with op NONE or reserved: no state change.
REQ-021 MULT: {hi,lo} = signed 2*WIDTH-bit product; MULTU: unsigned product.
REQ-022 DIV: lo = quotient truncated toward zero, hi = remainder with dividend's sign; DIVU: unsigned quotient/remainder.
REQ-023 Signed overflow (rs = most-negative, rt = -1): lo = most-negative, hi = 0.
REQ-024 Divisor zero (DIV or DIVU): still runs DIV_LAT cycles and pulses done; hi/lo unchanged.
REQ-025 Result may be computed at accept or completion; committed values SHALL match REQ-021..024 regardless.
REQ-026 hi/lo hold value in all cycles other than commit or MTHI/MTLO edges.

Reset
REQ-027 reset=1 at an edge: state IDLE, counter 0, busy=0, done=0, hi=0, lo=0; dominates start.
REQ-028 Reset mid-operation discards the in-flight result; no done pulse follows.
REQ-029 Every output is defined (no X) from the first edge with reset=1.

Verification (WIDTH=32, MULT_LAT=5, DIV_LAT=10)
REQ-030 MULT rs=0xFFFFFFFF rt=0x00000002 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE, done one cycle.
REQ-031 MULTU rs=0xFFFFFFFF rt=0x00000002 -> hi=0x00000001 lo=0xFFFFFFFE after 5 cycles.
REQ-032 DIV rs=0xFFFFFFF9 (-7) rt=2 -> after 10 cycles lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU rs=7 rt=2 -> lo=3 hi=1; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-033 MTHI 0x12345678 then DIVU rs=5 rt=0 -> busy 10 cycles, done pulses, hi=0x12345678 and lo unchanged.
REQ-034 DIVU accepted, then at busy cycle 3 drive start with MULT and MTLO 0xAAAA -> both ignored, DIVU result commits at cycle 10; MTLO 0xAAAA when idle -> lo=0x0000AAAA next cycle.
REQ-035 MULT accepted, reset=1 at busy cycle 3 -> next cycle busy=0, hi=lo=0, no done pulse afterward.
